// File: rtl/data_memory.sv
// rtl/data_memory.sv - word-addressed data RAM with post-reset zero-fill sweep
module data_memory #(
    parameter int ADDR_WIDTH     = 15,
    parameter int DATA_WIDTH     = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  init_done
);

    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] PTR_STEP  = 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] clear_ptr;
    logic                  init_done_q;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Sweep pointer and ready flag; reset restarts the sweep from address 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_ptr   <= '0;
            init_done_q <= 1'b0;
        end else if (!init_done_q) begin
            if (CLEAR_ON_RESET != 0) begin
                clear_ptr <= clear_ptr + PTR_STEP;
                if (clear_ptr == LAST_ADDR) begin
                    init_done_q <= 1'b1;
                end
            end else begin
                init_done_q <= 1'b1;
            end
        end
    end

    // Single write port shared by the zero-fill sweep and normal stores
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = data_address;
        mem_wdata = write_data;
        if (rst_n) begin
            if (init_done_q) begin
                mem_we = write_en;
            end else if (CLEAR_ON_RESET != 0) begin
                mem_we    = 1'b1;
                mem_waddr = clear_ptr;
                mem_wdata = '0;
            end
        end
    end

    // Array write; no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign read_data = init_done_q ? mem[data_address] : '0;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - self-checking bench for data_memory
module tb_data_memory;

    localparam int AW = 15;
    localparam int DW = 32;
    localparam int DEPTH = 2 ** AW;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] data_address;
    logic          write_en;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;
    logic          init_done;

    int passed;
    int total;

    logic [DW-1:0] model [int];

    data_memory #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_address(data_address),
        .write_en    (write_en),
        .write_data  (write_data),
        .read_data   (read_data),
        .init_done   (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (init_done === 1'b1) begin
            assert (!$isunknown(write_en)) else $error("bench drove X on write_en");
        end
    end

    function automatic logic [DW-1:0] model_read(input int addr);
        if (model.exists(addr)) return model[addr];
        return '0;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int addr, input logic [DW-1:0] data);
        data_address = addr[AW-1:0];
        write_data   = data;
        write_en     = 1'b1;
        tick();
        model[addr]  = data;
        write_en     = 1'b0;
    endtask

    task automatic count_sweep(input string tag);
        int cycles;
        cycles = 0;
        while (init_done !== 1'b1 && cycles < 40000) begin
            tick();
            cycles++;
        end
        check(tag, cycles, DEPTH);
    endtask

    initial begin
        logic [DW-1:0] exp_data;
        int            addr;
        logic          we;
        logic [DW-1:0] wd;

        passed       = 0;
        total        = 0;
        rst_n        = 1'b0;
        data_address = '0;
        write_en     = 1'b0;
        write_data   = '0;

        // 1: reset, sweep length, cleared contents
        repeat (3) tick();
        data_address = 15'h1234;
        check("reset_init_done", {31'd0, init_done}, 32'd0);
        check("reset_read_zero", read_data, 32'd0);
        rst_n = 1'b1;
        count_sweep("sweep1_len");
        check("sweep1_done", {31'd0, init_done}, 32'd1);
        data_address = 15'h0000; #1 check("clr_0", read_data, 32'd0);
        data_address = 15'h1234; #1 check("clr_1234", read_data, 32'd0);
        data_address = 15'h7FFF; #1 check("clr_7fff", read_data, 32'd0);

        // 2: write disabled
        data_address = 15'h0000;
        write_data   = 32'h12345678;
        write_en     = 1'b0;
        tick();
        check("wr_disabled", read_data, 32'd0);

        // 3: consecutive writes
        do_write(0, 32'h12345678);
        do_write(1, 32'h87654321);
        do_write(2, 32'hABCDEF01);
        do_write(3, 32'h98765432);
        data_address = 15'd4;
        write_data   = 32'hFFFFFFFF;
        tick();
        for (int i = 0; i <= 4; i++) begin
            data_address = i[AW-1:0];
            #1 check($sformatf("wr_read_%0d", i), read_data, model_read(i));
        end

        // 4: read during write
        do_write(5, 32'hA5A5A5A5);
        data_address = 15'd5;
        write_data   = 32'h5A5A5A5A;
        write_en     = 1'b1;
        #1 check("rdw_before", read_data, 32'hA5A5A5A5);
        tick();
        write_en = 1'b0;
        model[5] = 32'h5A5A5A5A;
        check("rdw_after", read_data, 32'h5A5A5A5A);
        data_address = 15'd4; #1 check("rdw_addr4", read_data, 32'd0);
        data_address = 15'd5; #1 check("rdw_addr5", read_data, 32'h5A5A5A5A);

        // 5: boundary addresses do not alias
        do_write(32'h7FFF, 32'hDEADBEEF);
        do_write(0, 32'hCAFEF00D);
        data_address = 15'h7FFF; #1 check("bnd_7fff", read_data, 32'hDEADBEEF);
        data_address = 15'h0000; #1 check("bnd_0", read_data, 32'hCAFEF00D);

        // random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 2))
                0:       addr = $urandom_range(0, 15);
                1:       addr = $urandom_range(DEPTH - 16, DEPTH - 1);
                default: addr = $urandom_range(0, DEPTH - 1);
            endcase
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            data_address = addr[AW-1:0];
            write_en     = we;
            write_data   = wd;
            #1 check($sformatf("rnd_rd_%0d", n), read_data, model_read(addr));
            tick();
            if (we) model[addr] = wd;
            check($sformatf("rnd_post_%0d", n), read_data, model_read(addr));
        end
        write_en = 1'b0;

        // 6: reset mid-use, then again mid-sweep
        do_write(32'h0100, 32'h13579BDF);
        data_address = 15'h0100;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_rst_done", {31'd0, init_done}, 32'd0);
        check("async_rst_read", read_data, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (100) tick();
        check("mid_sweep_done", {31'd0, init_done}, 32'd0);
        check("mid_sweep_read", read_data, 32'd0);
        #3 rst_n = 1'b0;
        #1 check("mid_rst_done", {31'd0, init_done}, 32'd0);
        tick();
        rst_n = 1'b1;
        model.delete();
        count_sweep("sweep2_len");
        foreach (model[k]) begin end
        data_address = 15'h0100; #1 check("post_rst_0100", read_data, model_read(32'h0100));
        data_address = 15'h0000; #1 check("post_rst_0", read_data, model_read(0));
        data_address = 15'h7FFF; #1 check("post_rst_7fff", read_data, model_read(32'h7FFF));
        data_address = 15'h0005; #1 check("post_rst_5", read_data, model_read(5));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
